// File: rtl/encoder_volume_ctrl_if.sv
// ---------------------------------------------------------------------------
// encoder_volume_ctrl_if
// Bundles the encoder-decoder inputs, the CPU strobe/data bus and the volume
// outputs of encoder_volume_ctrl.
//   master : drives the encoder and CPU strobes, observes volume/status/test
//   slave  : the volume controller itself
// Handshake: every input strobe (enc_state_change_stb, vol_rd_stb,
// vol_wr_stb) is valid for exactly the cycles it is high; there is no ready
// signal because the controller accepts a strobe on every cycle. Data that
// qualifies a strobe (click, clockwise, vol_wr_data) is only meaningful in
// the cycle its strobe is high.
// ---------------------------------------------------------------------------
interface encoder_volume_ctrl_if;
  logic       enc_state_change_stb;
  logic       click;
  logic       clockwise;
  logic       enc_sw_value;
  logic       vol_rd_stb;
  logic       vol_wr_stb;
  logic [7:0] vol_wr_data;
  logic [6:0] vol_level;
  logic       mute;
  logic [7:0] vol_status_reg;
  logic [7:0] test;

  modport master (
    output enc_state_change_stb, click, clockwise, enc_sw_value,
    output vol_rd_stb, vol_wr_stb, vol_wr_data,
    input  vol_level, mute, vol_status_reg, test
  );

  modport slave (
    input  enc_state_change_stb, click, clockwise, enc_sw_value,
    input  vol_rd_stb, vol_wr_stb, vol_wr_data,
    output vol_level, mute, vol_status_reg, test
  );
endinterface

// File: rtl/encoder_volume_ctrl.sv
// ---------------------------------------------------------------------------
// encoder_volume_ctrl
// Turns rotary-encoder detents and the encoder push switch into a saturating
// 7-bit volume level, a mute toggle (short press) and a long-press event, and
// offers the CPU a read-to-clear status byte plus a direct volume write.
//
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : encoder_volume_ctrl_if.slave
//           in : enc_state_change_stb, click, clockwise, enc_sw_value,
//                vol_rd_stb, vol_wr_stb, vol_wr_data[7:0]
//           out: vol_level[6:0], mute, vol_status_reg[7:0], test[7:0]
//
// Status byte: [0] changed, [1] mute, [2] short_press, [3] long_press,
//              [4] at_limit, [5] last_dir, [7:6] 0
// Debug taps:  test[1:0] press state, [2] detent, [3] fast-step select
//
// Build option: define ENC_VOL_ACCEL_EN to enable speed acceleration (fast
// step for same-direction detents closer than ACCEL_WINDOW cycles). Without
// it every detent moves the level by one and no gap counter is built.
// LONG_PRESS must be at least 2.
// ---------------------------------------------------------------------------
module encoder_volume_ctrl #(
  parameter int VOL_MAX      = 100,
  parameter int VOL_INIT     = 40,
  parameter int ACCEL_WINDOW = 2000000,
  parameter int STEP_FAST    = 4,
  parameter int LONG_PRESS   = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  encoder_volume_ctrl_if.slave  bus
);

  localparam logic [6:0] VOL_MAX_W  = 7'(VOL_MAX);
  localparam logic [6:0] VOL_INIT_W = 7'(VOL_INIT);
  localparam int         TW         = (LONG_PRESS > 2) ? $clog2(LONG_PRESS) : 1;
  // Timer value in the cycle where it is about to reach LONG_PRESS-1.
  localparam logic [TW-1:0] TIMER_LAST = TW'(LONG_PRESS - 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } press_state_e;

  press_state_e  state_q;
  logic [TW-1:0] timer_q;

  logic [6:0] vol_q,      vol_d;
  logic       mute_q,     mute_d;
  logic       changed_q,  changed_d;
  logic       short_q,    short_d;
  logic       long_q,     long_d;
  logic       last_dir_q, last_dir_d;
  logic [7:0] status_q,   status_d;

  logic       detent;
  logic       detent_eff;
  logic       fast_sel;
  logic [7:0] step;
  logic [8:0] sum_w;
  logic [6:0] wr_val;
  logic       short_evt;
  logic       long_evt;
  logic       at_limit;
  logic [7:0] status_now;
  logic       unused_wr_msb;

  assign unused_wr_msb = bus.vol_wr_data[7];

  assign detent     = bus.enc_state_change_stb & bus.click;
  // A CPU write in the same cycle takes priority and the detent is dropped.
  assign detent_eff = detent & ~bus.vol_wr_stb;

`ifdef ENC_VOL_ACCEL_EN
  localparam int GAP_W = $clog2(ACCEL_WINDOW + 1);
  localparam logic [GAP_W-1:0] GAP_SAT = GAP_W'(ACCEL_WINDOW);

  logic [GAP_W-1:0] gap_q, gap_d;

  assign fast_sel = (gap_q < GAP_SAT) && (bus.clockwise == last_dir_q);

  // Cycles since the last detent; any detent clears it, even one that a
  // CPU write drops.
  always_comb begin
    gap_d = gap_q;
    if (detent) begin
      gap_d = '0;
    end else if (gap_q < GAP_SAT) begin
      gap_d = gap_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_q <= GAP_SAT;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign fast_sel = 1'b0;
`endif

  assign step       = fast_sel ? 8'(STEP_FAST) : 8'd1;
  assign sum_w      = {2'b00, vol_q} + {1'b0, step};
  assign wr_val     = (bus.vol_wr_data[6:0] > VOL_MAX_W) ? VOL_MAX_W : bus.vol_wr_data[6:0];
  assign at_limit   = (vol_q == 7'd0) || (vol_q == VOL_MAX_W);
  assign status_now = {2'b00, last_dir_q, at_limit, long_q, short_q, mute_q, changed_q};

  // Press events are decided from the current state so that their effect on
  // mute and the sticky flags lands at the same edge as the state change.
  assign short_evt = (state_q == ST_PRESSED) && !bus.enc_sw_value;
  assign long_evt  = (state_q == ST_PRESSED) && bus.enc_sw_value && (timer_q == TIMER_LAST);

  always_comb begin
    vol_d      = vol_q;
    mute_d     = mute_q;
    last_dir_d = last_dir_q;
    status_d   = status_q;

    if (bus.vol_wr_stb) begin
      vol_d = wr_val;
    end else if (detent_eff) begin
      if (bus.clockwise) begin
        vol_d = (sum_w > 9'(VOL_MAX)) ? VOL_MAX_W : sum_w[6:0];
      end else if ({1'b0, vol_q} < step) begin
        vol_d = 7'd0;
      end else begin
        vol_d = vol_q - step[6:0];
      end
    end

    if (detent_eff) begin
      last_dir_d = bus.clockwise;
    end

    // A short press in the same cycle as a detent toggles; otherwise a
    // detent un-mutes.
    if (short_evt) begin
      mute_d = ~mute_q;
    end else if (detent_eff) begin
      mute_d = 1'b0;
    end

    // Snapshot takes pre-edge values; a flag set this cycle survives the read.
    if (bus.vol_rd_stb) begin
      status_d = status_now;
    end
    changed_d = bus.vol_wr_stb | detent_eff | (changed_q & ~bus.vol_rd_stb);
    short_d   = short_evt | (short_q & ~bus.vol_rd_stb);
    long_d    = long_evt  | (long_q  & ~bus.vol_rd_stb);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vol_q      <= VOL_INIT_W;
      mute_q     <= 1'b0;
      changed_q  <= 1'b0;
      short_q    <= 1'b0;
      long_q     <= 1'b0;
      last_dir_q <= 1'b0;
      status_q   <= 8'h00;
    end else begin
      vol_q      <= vol_d;
      mute_q     <= mute_d;
      changed_q  <= changed_d;
      short_q    <= short_d;
      long_q     <= long_d;
      last_dir_q <= last_dir_d;
      status_q   <= status_d;
    end
  end

  // Press FSM: timer counts cycles spent in PRESSED.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.enc_sw_value) begin
            state_q <= ST_PRESSED;
            timer_q <= '0;
          end
        end
        ST_PRESSED: begin
          if (!bus.enc_sw_value) begin
            state_q <= ST_IDLE;
          end else if (timer_q == TIMER_LAST) begin
            state_q <= ST_HELD;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_HELD: begin
          if (!bus.enc_sw_value) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.vol_level      = vol_q;
  assign bus.mute           = mute_q;
  assign bus.vol_status_reg = status_q;
  assign bus.test           = {4'b0000, fast_sel, detent, state_q};

endmodule

// File: tb/tb_encoder_volume_ctrl.sv
module tb_encoder_volume_ctrl;
  localparam int VOL_MAX   = 100;
  localparam int VOL_INIT  = 40;
  localparam int AW        = 100;
  localparam int STEP_FAST = 4;
  localparam int LP        = 1000;
`ifdef ENC_VOL_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  encoder_volume_ctrl_if bus ();

  encoder_volume_ctrl #(
    .VOL_MAX(VOL_MAX), .VOL_INIT(VOL_INIT), .ACCEL_WINDOW(AW),
    .STEP_FAST(STEP_FAST), .LONG_PRESS(LP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // State kept in spec terms: level, flags, length of the current hold, and
  // the cycle of the previous detent.
  int       m_vol;
  bit       m_mute, m_changed, m_short, m_long, m_last_dir;
  logic [7:0] m_status;
  int       m_hold;
  int       m_cycle = 0;
  int       m_last_det;
  logic [15:0] exp_q[$];

  task automatic model_reset();
    m_vol = VOL_INIT; m_mute = 0; m_changed = 0; m_short = 0; m_long = 0;
    m_last_dir = 0; m_status = 8'h00; m_hold = 0; m_last_det = -1000000;
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic clear_strobes();
    bus.enc_state_change_stb = 0; bus.click = 0; bus.clockwise = 0;
    bus.vol_rd_stb = 0; bus.vol_wr_stb = 0; bus.vol_wr_data = 8'h00;
  endtask

  // Inputs are already set; predict, clock once, compare.
  task automatic step_cycle();
    bit det, det_eff, fast, sh, lg, rd, wr, cw;
    int stp, nv;
    logic [7:0] snap;
    logic [15:0] e;
    det     = bus.enc_state_change_stb && bus.click;
    wr      = bus.vol_wr_stb;
    rd      = bus.vol_rd_stb;
    cw      = bus.clockwise;
    det_eff = det && !wr;
    fast    = ACCEL && ((m_cycle - m_last_det) <= AW) && (cw == m_last_dir);
    #1;
    check("test_detent", bus.test[2], det);
    check("test_fast", bus.test[3], fast);
    check("test_zero", bus.test[7:4], 0);
    sh = 0; lg = 0;
    if (bus.enc_sw_value) begin
      if (m_hold == LP - 1) lg = 1;
      m_hold++;
    end else begin
      if (m_hold > 0 && m_hold < LP) sh = 1;
      m_hold = 0;
    end
    snap = {2'b00, m_last_dir, (m_vol == 0 || m_vol == VOL_MAX), m_long, m_short, m_mute, m_changed};
    nv = m_vol;
    if (wr) begin
      nv = int'(bus.vol_wr_data[6:0]);
      if (nv > VOL_MAX) nv = VOL_MAX;
    end else if (det_eff) begin
      stp = fast ? STEP_FAST : 1;
      if (cw) nv = (m_vol + stp > VOL_MAX) ? VOL_MAX : m_vol + stp;
      else    nv = (m_vol - stp < 0) ? 0 : m_vol - stp;
    end
    if (sh) m_mute = !m_mute;
    else if (det_eff) m_mute = 0;
    if (rd) m_status = snap;
    m_changed = wr || det_eff || (m_changed && !rd);
    m_short   = sh || (m_short && !rd);
    m_long    = lg || (m_long && !rd);
    if (det_eff) m_last_dir = cw;
    if (det) m_last_det = m_cycle;
    m_vol = nv;
    exp_q.push_back({7'(m_vol), m_mute, m_status});
    @(posedge clk);
    #1;
    m_cycle++;
    e = exp_q.pop_front();
    check("vol_level", bus.vol_level, e[15:9]);
    check("mute", bus.mute, e[8]);
    check("vol_status_reg", bus.vol_status_reg, e[7:0]);
    clear_strobes();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step_cycle();
  endtask

  task automatic detent(input bit cw);
    bus.enc_state_change_stb = 1; bus.click = 1; bus.clockwise = cw;
    step_cycle();
  endtask

  task automatic cpu_read();
    bus.vol_rd_stb = 1;
    step_cycle();
  endtask

  task automatic cpu_write(input logic [7:0] d);
    bus.vol_wr_stb = 1; bus.vol_wr_data = d;
    step_cycle();
  endtask

  task automatic apply_reset();
    clear_strobes();
    bus.enc_sw_value = 0;
    #2;
    reset = 1;
    #1;
    check("rst_vol", bus.vol_level, VOL_INIT);
    check("rst_mute", bus.mute, 0);
    check("rst_status", bus.vol_status_reg, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_strobes();
    bus.enc_sw_value = 0;
    apply_reset();
    check("rst_fsm", bus.test[1:0], 0);

    // Slow clockwise detents
    idle(10);
    detent(1); check("slow_1", bus.vol_level, 41);
    idle(499);
    detent(1); check("slow_2", bus.vol_level, 42);
    idle(499);
    detent(1); check("slow_3", bus.vol_level, 43);
    idle(2);
    cpu_read(); check("slow_status", bus.vol_status_reg, 8'h21);

    // Fast spin and reversal
    apply_reset();
    detent(1); check("fast_1", bus.vol_level, 41);
    idle(19);
    detent(1); check("fast_2", bus.vol_level, ACCEL ? 45 : 42);
    idle(19);
    detent(1); check("fast_3", bus.vol_level, ACCEL ? 49 : 43);
    idle(19);
    detent(0); check("reverse", bus.vol_level, ACCEL ? 48 : 42);

    // Limits
    idle(5);
    cpu_write(8'h7F); check("wr_clamp", bus.vol_level, 100);
    detent(1); check("top_hold", bus.vol_level, 100);
    cpu_read();
    check("top_changed", bus.vol_status_reg[0], 1);
    check("top_at_limit", bus.vol_status_reg[4], 1);
    cpu_write(8'h00);
    detent(0); check("bottom_hold", bus.vol_level, 0);
    idle(3);

    // Short press
    bus.enc_sw_value = 1; idle(200);
    bus.enc_sw_value = 0; step_cycle();
    check("short_mute", bus.mute, 1);
    cpu_read();
    check("short_flag", bus.vol_status_reg[2], 1);
    idle(5);

    // Long press: event at hold cycle 999, read in that cycle sees it clear
    bus.enc_sw_value = 1; idle(999);
    cpu_read(); check("long_not_yet", bus.vol_status_reg[3], 0);
    idle(500);
    bus.enc_sw_value = 0; step_cycle();
    check("long_mute_kept", bus.mute, 1);
    cpu_read(); check("long_flag", bus.vol_status_reg[3], 1);
    cpu_read(); check("flags_cleared", bus.vol_status_reg[3:2], 0);

    // Collisions
    bus.vol_rd_stb = 1; detent(1);
    cpu_read(); check("rd_vs_detent", bus.vol_status_reg[0], 1);
    idle(3);
    bus.vol_wr_stb = 1; bus.vol_wr_data = 8'h10; detent(1);
    check("wr_vs_detent", bus.vol_level, 16);
    idle(3);

    // Async reset mid-press
    bus.enc_sw_value = 1; idle(50);
    bus.enc_sw_value = 0; step_cycle();
    check("pre_rst_mute", bus.mute, 1);
    bus.enc_sw_value = 1; idle(601);
    #3;
    reset = 1;
    bus.enc_sw_value = 0;
    #1;
    check("arst_vol", bus.vol_level, VOL_INIT);
    check("arst_mute", bus.mute, 0);
    check("arst_status", bus.vol_status_reg, 0);
    check("arst_fsm", bus.test[1:0], 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 0;
    model_reset();
    idle(20);
    check("arst_no_toggle", bus.mute, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 8000; i++) begin
      bus.enc_state_change_stb = ($urandom_range(0, 24) == 0);
      bus.click     = ($urandom_range(0, 3) != 0);
      bus.clockwise = ($urandom_range(0, 2) != 0);
      if (bus.enc_sw_value) begin
        if ($urandom_range(0, 499) == 0) bus.enc_sw_value = 0;
      end else begin
        if ($urandom_range(0, 149) == 0) bus.enc_sw_value = 1;
      end
      bus.vol_rd_stb  = ($urandom_range(0, 19) == 0);
      bus.vol_wr_stb  = ($urandom_range(0, 59) == 0);
      bus.vol_wr_data = 8'($urandom_range(0, 255));
      step_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
